// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: walks FETCH/DECODE/EXEC/MEM/WB, raises
// datapath strobes, counts retired instructions and traps on memory timeouts.
module cpu_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src_sel,
  output logic        rf_write_en,
  output logic        busy,
  output logic [2:0]  state,
  output logic [15:0] instr_count,
  output logic        timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               branch_q;
  logic               timeout_q;
  logic [15:0]        count_q;
  logic               wait_expired;
  logic               in_request;

  // The request in flight has already missed TIMEOUT-1 cycles; one more miss traps.
  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign in_request   = (state_q == S_FETCH) || (state_q == S_MEM);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src_sel   = 1'b0;
    rf_write_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        state_d = halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (mem_read || mem_write) begin
          state_d = S_MEM;
        end else if (reg_write) begin
          state_d = S_WB;
        end else begin
          pc_write   = 1'b1;
          pc_src_sel = branch_taken;
          state_d    = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = mem_write;
        if (mem_ready) begin
          // A read+write combination behaves as a store and skips write-back.
          if (mem_write) begin
            pc_write   = 1'b1;
            pc_src_sel = branch_q;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        rf_write_en = 1'b1;
        pc_write    = 1'b1;
        pc_src_sel  = branch_q;
        state_d     = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
    endcase
  end

  // Wait counter restarts on each fresh entry to a request state.
  always_comb begin
    wait_d = wait_q;
    if ((state_d == S_FETCH || state_d == S_MEM) && (state_d != state_q)) begin
      wait_d = '0;
    end else if (in_request && !mem_ready) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      branch_q  <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | (state_d == S_ERR);
      count_q   <= count_q + {15'd0, pc_write};
      if (state_q == S_EXEC) branch_q <= branch_taken;
    end
  end

  assign busy        = (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
  assign state       = state_q;
  assign instr_count = count_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction table with a scoreboard
// queue plus hand-written sequences for halt, timeout, reset and wrap.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src_sel;
  logic        rf_write_en, busy, timeout_err;
  logic [2:0]  state;
  logic [15:0] instr_count;

  cpu_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .halt(halt), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src_sel(pc_src_sel),
    .rf_write_en(rf_write_en), .busy(busy), .state(state),
    .instr_count(instr_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, rw, br;
    int   fwait, mwait;
    int   cycles, req, rf, we, src;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       ir, pc, rf;
  } cyc_t;

  vec_t        vecs[10];
  vec_t        sb_q[$];
  cyc_t        cyc_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_count = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, rw, br, input int fwait, mwait,
                              cycles, req, rf, we, src);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.br = br;
    v.fwait = fwait; v.mwait = mwait;
    v.cycles = cycles; v.req = req; v.rf = rf; v.we = we; v.src = src;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_start();
    rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    reg_write = 1'b0; halt = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    exp_count = 16'd0;
    #1;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starts with the DUT freshly in FETCH; returns one cycle after pc_write.
  task automatic run_vec(input int idx, input vec_t v);
    int         cycles, fcnt, mcnt, n_ir, n_pc, n_rf, n_we, n_src, n_req;
    logic       pcw, done;
    logic [2:0] cur;
    vec_t       e;
    cycles = 0; fcnt = 0; mcnt = 0; n_ir = 0; n_pc = 0; n_rf = 0;
    n_we = 0; n_src = 0; n_req = 0; done = 1'b0;
    mem_read = v.rd; mem_write = v.wr; reg_write = v.rw; halt = 1'b0;
    branch_taken = v.br;
    sb_q.push_back(v);
    while (!done && cycles < 64) begin
      cur = state;
      case (cur)
        3'd1: begin mem_ready = (fcnt == v.fwait); fcnt++; end
        3'd4: begin mem_ready = (mcnt == v.mwait); mcnt++; branch_taken = ~v.br; end
        3'd5: begin mem_ready = 1'b1; branch_taken = ~v.br; end
        default: mem_ready = 1'b1;
      endcase
      @(negedge clk);
      n_ir  += int'(ir_write);
      n_pc  += int'(pc_write);
      n_rf  += int'(rf_write_en);
      n_we  += int'(mem_we);
      n_src += int'(pc_src_sel);
      n_req += int'(mem_req);
      pcw = pc_write;
      cycles++;
      tick();
      if (pcw) done = 1'b1;
    end
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    e = sb_q.pop_front();
    exp_count = exp_count + 16'd1;
    check($sformatf("v%0d completed", idx), 32'(done), 32'd1);
    check($sformatf("v%0d ir_write", idx), n_ir, 1);
    check($sformatf("v%0d pc_write", idx), n_pc, 1);
    check($sformatf("v%0d rf_write_en", idx), n_rf, e.rf);
    check($sformatf("v%0d mem_we", idx), n_we, e.we);
    check($sformatf("v%0d pc_src_sel", idx), n_src, e.src);
    check($sformatf("v%0d mem_req", idx), n_req, e.req);
    check($sformatf("v%0d cycles", idx), cycles, e.cycles);
    check($sformatf("v%0d end state", idx), 32'(state), 32'd1);
    check($sformatf("v%0d instr_count", idx), 32'(instr_count), 32'(exp_count));
  endtask

  initial begin
    cyc_t c;

    //          rd wr rw br  fw mw  cyc req rf we src
    vecs[0] = mk(0, 0, 1, 0,  0, 0,   4,  1, 1, 0, 0);  // ALU
    vecs[1] = mk(0, 0, 1, 1,  1, 0,   5,  2, 1, 0, 1);  // ALU, branch_q used in WB
    vecs[2] = mk(1, 0, 0, 1,  2, 3,  10,  7, 1, 0, 1);  // load, waits in both
    vecs[3] = mk(0, 1, 0, 1,  0, 1,   5,  3, 0, 2, 1);  // store
    vecs[4] = mk(1, 1, 0, 0,  0, 0,   4,  2, 0, 1, 0);  // read+write acts as store
    vecs[5] = mk(0, 0, 0, 1,  0, 0,   3,  1, 0, 0, 1);  // taken branch
    vecs[6] = mk(0, 0, 0, 0,  3, 0,   6,  4, 0, 0, 0);  // not-taken branch
    vecs[7] = mk(0, 1, 1, 0,  0, 0,   4,  2, 0, 1, 0);  // store wins over reg_write
    vecs[8] = mk(0, 0, 1, 0, 15, 0,  19, 16, 1, 0, 0);  // ready on last fetch cycle
    vecs[9] = mk(1, 0, 0, 0,  0, 15, 20, 17, 1, 0, 0);  // ready on last mem cycle

    // Reset values while rst_n is low
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset instr_count", 32'(instr_count), 32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);

    // ALU instruction with memory always ready: 1,2,3,5,1
    tick();
    rst_n = 1'b1; reg_write = 1'b1; mem_ready = 1'b1; start = 1'b1;
    c = '{st: 3'd1, ir: 1'b1, pc: 1'b0, rf: 1'b0}; cyc_q.push_back(c);
    c = '{st: 3'd2, ir: 1'b0, pc: 1'b0, rf: 1'b0}; cyc_q.push_back(c);
    c = '{st: 3'd3, ir: 1'b0, pc: 1'b0, rf: 1'b0}; cyc_q.push_back(c);
    c = '{st: 3'd5, ir: 1'b0, pc: 1'b1, rf: 1'b1}; cyc_q.push_back(c);
    c = '{st: 3'd1, ir: 1'b1, pc: 1'b0, rf: 1'b0}; cyc_q.push_back(c);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c = cyc_q.pop_front();
      check($sformatf("alu seq%0d state", i), 32'(state), 32'(c.st));
      check($sformatf("alu seq%0d ir_write", i), 32'(ir_write), 32'(c.ir));
      check($sformatf("alu seq%0d pc_write", i), 32'(pc_write), 32'(c.pc));
      check($sformatf("alu seq%0d rf_write_en", i), 32'(rf_write_en), 32'(c.rf));
      tick();
    end
    check("alu instr_count", 32'(instr_count), 32'd1);

    // Table of instructions run back to back
    reset_and_start();
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // halt has priority in DECODE, then start is ignored
    reset_and_start();
    halt = 1'b1; mem_read = 1'b1; reg_write = 1'b1; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("halt decode state", 32'(state), 32'd2);
    tick();
    check("halt state", 32'(state), 32'd6);
    check("halt busy", 32'(busy), 32'd0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("halt hold%0d state", i), 32'(state), 32'd6);
      check($sformatf("halt hold%0d mem_req", i), 32'(mem_req), 32'd0);
      check($sformatf("halt hold%0d pc_write", i), 32'(pc_write), 32'd0);
      tick();
    end
    check("halt instr_count", 32'(instr_count), 32'd0);

    // FETCH timeout after 16 non-ready cycles
    reset_and_start();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("timeout wait%0d state", i), 32'(state), 32'd1);
      tick();
    end
    check("timeout state", 32'(state), 32'd7);
    check("timeout timeout_err", 32'(timeout_err), 32'd1);
    check("timeout mem_req", 32'(mem_req), 32'd0);
    check("timeout busy", 32'(busy), 32'd0);
    start = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    check("timeout sticky state", 32'(state), 32'd7);
    check("timeout sticky err", 32'(timeout_err), 32'd1);
    start = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("timeout cleared state", 32'(state), 32'd0);
    check("timeout cleared err", 32'(timeout_err), 32'd0);

    // Asynchronous reset in the middle of a memory access
    reset_and_start();
    mem_read = 1'b1; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("mid-mem state", 32'(state), 32'd4);
    check("mid-mem mem_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset mem_req", 32'(mem_req), 32'd0);
    check("async reset state", 32'(state), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1; mem_read = 1'b0;
    tick();
    tick();
    check("idle after reset", 32'(state), 32'd0);

    // instr_count wrap: preload the counter just below the wrap point
    reset_and_start();
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    exp_count = 16'hFFFF;
    check("wrap preload", 32'(instr_count), 32'h0000FFFF);
    run_vec(10, vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
